// File: rtl/param_memory_if.sv
// param_memory_if: request/response bus between a requester and param_memory.
interface param_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                    rd_en;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic                    rd_valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rd_err;
    logic                    err;
    logic                    par_err;
    logic                    init_done;

    modport master (
        output rd_en, wr_en, addr, wdata, be,
        input  ready, rd_valid, rdata, rd_err, err, par_err, init_done
    );
    modport slave (
        input  rd_en, wr_en, addr, wdata, be,
        output ready, rd_valid, rdata, rd_err, err, par_err, init_done
    );
endinterface

// File: rtl/param_memory.sv
// param_memory: byte-enabled single-port memory with clear sweep after reset and pipelined reads.
// Optional per-byte even parity enabled by defining PARAM_MEMORY_PARITY_EN.
module param_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int RD_LATENCY = 1
) (
    input logic          clk,
    input logic          reset,
    param_memory_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int L  = RD_LATENCY;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {INIT, IDLE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    rdy;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    in_range;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    perr;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [L-1:0]            v;
    logic [L-1:0]            e;
    logic [L-1:0]            p;
    logic [DATA_WIDTH-1:0]   d [L];

    assign in_range = {1'b0, bus.addr} < DEPTH_W;
    assign rd_acc   = rdy & bus.rd_en & ~bus.wr_en;
    assign wr_acc   = rdy & bus.wr_en & ~bus.rd_en & in_range;
    assign rd_word  = mem[bus.addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
            rdy   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= rdy & bus.wr_en & (bus.rd_en | ~in_range);
            if (state == INIT) begin
                ptr <= ptr + 1'b1;
                if (ptr == LAST) begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[ptr] <= '0;
        else if (wr_acc)
            for (int i = 0; i < NB; i++)
                if (bus.be[i]) mem[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
    end

`ifdef PARAM_MEMORY_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wpar;
    logic [NB-1:0] rpar;

    always_comb begin
        wpar = '0;
        rpar = '0;
        for (int i = 0; i < NB; i++) begin
            wpar[i] = ^bus.wdata[8*i +: 8];
            rpar[i] = ^rd_word[8*i +: 8];
        end
    end

    assign perr = |(rpar ^ par_mem[bus.addr]);

    always_ff @(posedge clk) begin
        if (state == INIT)
            par_mem[ptr] <= '0;
        else if (wr_acc)
            for (int i = 0; i < NB; i++)
                if (bus.be[i]) par_mem[bus.addr][i] <= wpar[i];
    end
`else
    assign perr = 1'b0;
`endif

    // Stage 0 captures on the accepting edge, so data reflects writes committed before it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
            e <= '0;
            p <= '0;
            for (int i = 0; i < L; i++) d[i] <= '0;
        end else begin
            v[0] <= rd_acc;
            e[0] <= rd_acc & ~in_range;
            p[0] <= rd_acc & in_range & perr;
            d[0] <= (rd_acc & in_range) ? rd_word : '0;
            for (int i = 1; i < L; i++) begin
                v[i] <= v[i-1];
                e[i] <= e[i-1];
                p[i] <= p[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign bus.ready     = rdy;
    assign bus.init_done = rdy;
    assign bus.err       = err_q;
    assign bus.rd_valid  = v[L-1];
    assign bus.rd_err    = e[L-1];
    assign bus.par_err   = p[L-1];
    assign bus.rdata     = d[L-1];
endmodule
